// File: rtl/flght_mixer_pd_if.sv
// Inertial/command inputs and ESC speed outputs of the flight mixer, grouped as one bus.
// master drives the sensor/command side, slave is the mixer core.
interface flght_mixer_pd_if #(
  parameter int ANG_W   = 16,
  parameter int THRST_W = 9,
  parameter int SPD_W   = 11
);
  logic                    arm;
  logic                    inertial_cal;
  logic                    vld;
  logic signed [ANG_W-1:0] d_ptch;
  logic signed [ANG_W-1:0] d_roll;
  logic signed [ANG_W-1:0] d_yaw;
  logic signed [ANG_W-1:0] ptch;
  logic signed [ANG_W-1:0] roll;
  logic signed [ANG_W-1:0] yaw;
  logic [THRST_W-1:0]      thrst;
  logic [SPD_W-1:0]        frnt_spd;
  logic [SPD_W-1:0]        bck_spd;
  logic [SPD_W-1:0]        lft_spd;
  logic [SPD_W-1:0]        rght_spd;
  logic                    spd_vld;

  modport master (
    output arm, inertial_cal, vld, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
    input  frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld
  );

  modport slave (
    input  arm, inertial_cal, vld, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
    output frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld
  );
endinterface

// File: rtl/flght_mixer_pd.sv
// Three-axis PD flight controller feeding a 4-motor mixer, with arm/calibration FSM and 3-stage pipeline.
// Define FLGHT_MIXER_SLEW_EN to limit each RUN update to SLEW_STEP per motor.
module flght_mixer_pd #(
  parameter int ANG_W         = 16,
  parameter int THRST_W       = 9,
  parameter int SPD_W         = 11,
  parameter int P_SAT_W       = 10,
  parameter int D_DEPTH       = 12,
  parameter int D_COEFF       = 7,
  parameter int CAL_SPEED     = 'h290,
  parameter int MIN_RUN_SPEED = 'h2C0,
  parameter int SLEW_STEP     = 16
) (
  input logic             clk,
  input logic             rst_n,
  flght_mixer_pd_if.slave bus
);
  localparam int PD_W  = SPD_W + 2;
  localparam int DD_W  = 7;
  localparam int PTR_W = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;
  localparam logic signed [PD_W-1:0] D_COEFF_W = PD_W'(D_COEFF);
  localparam logic signed [PD_W-1:0] MIN_W     = PD_W'(MIN_RUN_SPEED);
  localparam logic signed [PD_W-1:0] FULL_W    = PD_W'((1 << SPD_W) - 1);
  localparam logic signed [PD_W-1:0] STEP_W    = PD_W'(SLEW_STEP);
`ifdef FLGHT_MIXER_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_CAL, ST_RUN} state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic                    flush;
  logic                    accept;
  logic                    keep;
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic                    s1_vld_reg;
  logic                    s2_vld_reg;
  logic [THRST_W-1:0]      thrst_s1_reg;
  logic [THRST_W-1:0]      thrst_s2_reg;
  logic signed [ANG_W-1:0] act [3];
  logic signed [ANG_W-1:0] des [3];
  logic signed [PD_W-1:0]  pd [3];
  logic signed [PD_W-1:0]  base;
  logic signed [PD_W-1:0]  mix [4];
  logic [SPD_W-1:0]        run_spd [4];
  logic [SPD_W-1:0]        spd_reg [4];
  logic                    spd_vld_reg;

  always_comb begin
    state_next = state_reg;
    if (!bus.arm) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (bus.inertial_cal)  state_next = ST_CAL;
        ST_CAL:  if (!bus.inertial_cal) state_next = ST_RUN;
        ST_RUN:  if (bus.inertial_cal)  state_next = ST_CAL;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Decisions use the next state so a disarm blanks the motors on the very next cycle.
  assign flush  = (state_next == ST_IDLE);
  assign accept = bus.vld && !flush;
  assign keep   = (state_next == ST_RUN);

  assign act[0] = bus.ptch;
  assign act[1] = bus.roll;
  assign act[2] = bus.yaw;
  assign des[0] = bus.d_ptch;
  assign des[1] = bus.d_roll;
  assign des[2] = bus.d_yaw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
    end else if (accept) begin
      wr_ptr_reg <= (wr_ptr_reg == PTR_W'(D_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
  end

  // Results only travel while RUN persists; CAL still feeds the derivative queues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_reg   <= 1'b0;
      s2_vld_reg   <= 1'b0;
      thrst_s1_reg <= '0;
      thrst_s2_reg <= '0;
    end else begin
      s1_vld_reg <= accept && keep;
      s2_vld_reg <= s1_vld_reg && keep;
      if (accept)     thrst_s1_reg <= bus.thrst;
      if (s1_vld_reg) thrst_s2_reg <= thrst_s1_reg;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_axis
    logic signed [ANG_W:0]     err;
    logic signed [P_SAT_W-1:0] err_sat;
    logic signed [P_SAT_W-1:0] err_s1_reg;
    logic signed [P_SAT_W-1:0] old_s1_reg;
    logic signed [P_SAT_W-1:0] p_half;
    logic signed [P_SAT_W-1:0] p_eighth;
    logic signed [P_SAT_W:0]   diff;
    logic signed [DD_W-1:0]    d_diff;
    logic signed [PD_W-1:0]    pterm;
    logic signed [PD_W-1:0]    dterm;
    logic signed [PD_W-1:0]    pd_s2_reg;
    logic signed [P_SAT_W-1:0] dq_reg [D_DEPTH];

    assign err = {act[gi][ANG_W-1], act[gi]} - {des[gi][ANG_W-1], des[gi]};
    // Saturate when the bits above the target sign bit are not all copies of it.
    assign err_sat = (&err[ANG_W:P_SAT_W-1] || ~|err[ANG_W:P_SAT_W-1]) ?
                     err[P_SAT_W-1:0] : {err[ANG_W], {(P_SAT_W-1){~err[ANG_W]}}};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < D_DEPTH; i++) dq_reg[i] <= '0;
        err_s1_reg <= '0;
        old_s1_reg <= '0;
      end else if (flush) begin
        for (int i = 0; i < D_DEPTH; i++) dq_reg[i] <= '0;
      end else if (accept) begin
        dq_reg[wr_ptr_reg] <= err_sat;
        err_s1_reg         <= err_sat;
        old_s1_reg         <= dq_reg[wr_ptr_reg];
      end
    end

    assign p_half   = err_s1_reg >>> 1;
    assign p_eighth = err_s1_reg >>> 3;
    assign pterm    = {{(PD_W-P_SAT_W){p_half[P_SAT_W-1]}}, p_half} +
                      {{(PD_W-P_SAT_W){p_eighth[P_SAT_W-1]}}, p_eighth};
    assign diff     = {err_s1_reg[P_SAT_W-1], err_s1_reg} - {old_s1_reg[P_SAT_W-1], old_s1_reg};
    assign d_diff   = (&diff[P_SAT_W:DD_W-1] || ~|diff[P_SAT_W:DD_W-1]) ?
                      diff[DD_W-1:0] : {diff[P_SAT_W], {(DD_W-1){~diff[P_SAT_W]}}};
    assign dterm    = $signed({{(PD_W-DD_W){d_diff[DD_W-1]}}, d_diff}) * D_COEFF_W;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pd_s2_reg <= '0;
      end else if (s1_vld_reg) begin
        pd_s2_reg <= pterm + dterm;
      end
    end

    assign pd[gi] = pd_s2_reg;
  end

  assign base   = $signed({{(PD_W-THRST_W){1'b0}}, thrst_s2_reg}) + MIN_W;
  assign mix[0] = base - pd[0] - pd[2];
  assign mix[1] = base + pd[0] - pd[2];
  assign mix[2] = base - pd[1] + pd[2];
  assign mix[3] = base + pd[1] + pd[2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_motor
    logic signed [PD_W-1:0] tgt;
    logic signed [PD_W-1:0] cur;
    logic signed [PD_W-1:0] delta;
    logic signed [PD_W-1:0] slewed;

    always_comb begin
      tgt = mix[gi];
      if (mix[gi] < MIN_W) begin
        tgt = MIN_W;
      end else if (mix[gi] > FULL_W) begin
        tgt = FULL_W;
      end
    end

    assign cur   = $signed({2'b00, spd_reg[gi]});
    assign delta = tgt - cur;

    always_comb begin
      slewed = tgt;
      if (delta > STEP_W) begin
        slewed = cur + STEP_W;
      end else if (delta < -STEP_W) begin
        slewed = cur - STEP_W;
      end
    end

    assign run_spd[gi] = SPD_W'(SLEW_ON ? slewed : tgt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      spd_vld_reg <= 1'b0;
      for (int i = 0; i < 4; i++) spd_reg[i] <= '0;
    end else begin
      state_reg   <= state_next;
      spd_vld_reg <= 1'b0;
      case (state_next)
        ST_IDLE: for (int i = 0; i < 4; i++) spd_reg[i] <= '0;
        ST_CAL:  for (int i = 0; i < 4; i++) spd_reg[i] <= SPD_W'(CAL_SPEED);
        ST_RUN: begin
          if (s2_vld_reg) begin
            for (int i = 0; i < 4; i++) spd_reg[i] <= run_spd[i];
            spd_vld_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.frnt_spd = spd_reg[0];
  assign bus.bck_spd  = spd_reg[1];
  assign bus.lft_spd  = spd_reg[2];
  assign bus.rght_spd = spd_reg[3];
  assign bus.spd_vld  = spd_vld_reg;
endmodule

// File: tb/tb_flght_mixer_pd.sv
// Self-checking bench for flght_mixer_pd: directed scenarios then random traffic against a queue-based model.
module tb_flght_mixer_pd;
  localparam int ANG_W     = 16;
  localparam int THRST_W   = 9;
  localparam int SPD_W     = 11;
  localparam int P_SAT_W   = 10;
  localparam int D_DEPTH   = 12;
  localparam int D_COEFF   = 7;
  localparam int CAL_SPEED = 'h290;
  localparam int MIN_RUN   = 'h2C0;
  localparam int FULL      = 2047;
  localparam int SLEW_STEP = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  flght_mixer_pd_if #(.ANG_W(ANG_W), .THRST_W(THRST_W), .SPD_W(SPD_W)) bus ();

  flght_mixer_pd #(
    .ANG_W(ANG_W), .THRST_W(THRST_W), .SPD_W(SPD_W), .P_SAT_W(P_SAT_W),
    .D_DEPTH(D_DEPTH), .D_COEFF(D_COEFF), .CAL_SPEED(CAL_SPEED),
    .MIN_RUN_SPEED(MIN_RUN), .SLEW_STEP(SLEW_STEP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int due;
    int spd[4];
  } res_t;

  res_t pend[$];
  int   hist[3][$];
  int   mode;      // 0 idle, 1 cal, 2 run
  int   edge_no;
  int   pass_cnt;
  int   fail_cnt;
  int   total_cnt;
  int   exp_spd[4];
  int   exp_vld;

  function automatic int sat(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int slew(input int cur, input int tgt);
`ifdef FLGHT_MIXER_SLEW_EN
    return (tgt - cur > SLEW_STEP) ? cur + SLEW_STEP :
           (cur - tgt > SLEW_STEP) ? cur - SLEW_STEP : tgt;
`else
    return tgt + 0 * cur;
`endif
  endfunction

  function automatic logic signed [ANG_W-1:0] rnd_ang();
    int r;
    if ($urandom_range(3) == 0) r = int'($urandom);
    else r = int'($urandom_range(600)) - 300;
    return ANG_W'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic flush_model();
    for (int a = 0; a < 3; a++) begin
      hist[a].delete();
      repeat (D_DEPTH) hist[a].push_back(0);
    end
    pend.delete();
  endtask

  // One inertial sample: saturate errors, age through the queue, PD + mix + clamp.
  task automatic model_sample(output int spd[4]);
    int act[3], des[3], pd[3], base, m[4], e, old;
    act = '{int'(bus.ptch), int'(bus.roll), int'(bus.yaw)};
    des = '{int'(bus.d_ptch), int'(bus.d_roll), int'(bus.d_yaw)};
    for (int a = 0; a < 3; a++) begin
      e   = sat(act[a] - des[a], -(1 << (P_SAT_W - 1)), (1 << (P_SAT_W - 1)) - 1);
      old = hist[a].pop_front();
      hist[a].push_back(e);
      pd[a] = (e >>> 1) + (e >>> 3) + sat(e - old, -64, 63) * D_COEFF;
    end
    base = int'(bus.thrst) + MIN_RUN;
    m[0] = base - pd[0] - pd[2];
    m[1] = base + pd[0] - pd[2];
    m[2] = base - pd[1] + pd[2];
    m[3] = base + pd[1] + pd[2];
    for (int i = 0; i < 4; i++) spd[i] = sat(m[i], MIN_RUN, FULL);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".frnt"}, 32'(bus.frnt_spd), exp_spd[0]);
    chk({tag, ".bck"},  32'(bus.bck_spd),  exp_spd[1]);
    chk({tag, ".lft"},  32'(bus.lft_spd),  exp_spd[2]);
    chk({tag, ".rght"}, 32'(bus.rght_spd), exp_spd[3]);
    chk({tag, ".vld"},  32'(bus.spd_vld),  exp_vld);
  endtask

  task automatic cyc(input logic a, input logic c, input logic v);
    int   nmode;
    int   tgt[4];
    res_t r;
    bus.arm = a;
    bus.inertial_cal = c;
    bus.vld = v;
    if (!a) nmode = 0;
    else if (mode == 0) nmode = c ? 1 : 0;
    else nmode = c ? 1 : 2;
    if (nmode != 2) pend.delete();
    if (nmode == 0) begin
      flush_model();
    end else if (v) begin
      model_sample(tgt);
      if (nmode == 2) begin
        r.due = edge_no + 2;
        r.spd = tgt;
        pend.push_back(r);
      end
    end
    exp_vld = 0;
    if (nmode == 0) begin
      exp_spd = '{0, 0, 0, 0};
    end else if (nmode == 1) begin
      exp_spd = '{CAL_SPEED, CAL_SPEED, CAL_SPEED, CAL_SPEED};
    end else if (pend.size() > 0 && pend[0].due == edge_no) begin
      for (int i = 0; i < 4; i++) exp_spd[i] = slew(exp_spd[i], pend[0].spd[i]);
      exp_vld = 1;
      void'(pend.pop_front());
    end
    @(posedge clk);
    #1;
    mode = nmode;
    edge_no++;
    bus.vld = 1'b0;
    check_outputs("cyc");
  endtask

  task automatic set_angles(input int p, input int r, input int y, input int th);
    bus.d_ptch = '0;
    bus.d_roll = '0;
    bus.d_yaw  = '0;
    bus.ptch   = ANG_W'(p);
    bus.roll   = ANG_W'(r);
    bus.yaw    = ANG_W'(y);
    bus.thrst  = THRST_W'(th);
  endtask

  initial begin
    logic cal_lvl;
    logic a_rnd;
    pass_cnt = 0;
    fail_cnt = 0;
    total_cnt = 0;
    mode = 0;
    edge_no = 0;
    exp_spd = '{0, 0, 0, 0};
    exp_vld = 0;
    rst_n = 1'b0;
    bus.arm = 1'b0;
    bus.inertial_cal = 1'b0;
    bus.vld = 1'b0;
    set_angles(0, 0, 0, 0);
    flush_model();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;
    cyc(0, 0, 0);

    // Arm + calibrate, then drop calibration into RUN
    cyc(1, 1, 0);
    chk("cal_entry_frnt", 32'(bus.frnt_spd), 'h290);
    cyc(1, 1, 0);
    cyc(1, 0, 0);

    // Level flight: base speed on all motors, one-cycle spd_vld at N+3
    set_angles(0, 0, 0, 'h100);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("level_frnt", 32'(bus.frnt_spd), 'h3C0);
    chk("level_vld", 32'(bus.spd_vld), 1);
    cyc(1, 0, 0);
    chk("level_vld_drop", 32'(bus.spd_vld), 0);

    // Large pitch error: P and D both saturate
    set_angles(2000, 0, 0, 'h100);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("pitch_frnt", 32'(bus.frnt_spd), 'h2C0);
    chk("pitch_bck", 32'(bus.bck_spd), 'h6B7);
    chk("pitch_lft", 32'(bus.lft_spd), 'h3C0);

    // Roll + yaw with full thrust: upper clamp
    set_angles(0, 2000, 2000, 'h1FF);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("ry_rght", 32'(bus.rght_spd), 'h7FF);
    chk("ry_lft", 32'(bus.lft_spd), 'h4BF);

    // Disarm with a result in flight
    set_angles(0, 0, 0, 'h100);
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    chk("disarm_frnt", 32'(bus.frnt_spd), 0);
    repeat (3) cyc(0, 0, 0);

    // Re-arm: queue must read zero again
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    set_angles(2000, 0, 0, 'h100);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("rearm_bck", 32'(bus.bck_spd), 'h6B7);

    // CAL -> RUN first update (slew-limited when the option is built in)
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    set_angles(0, 0, 0, 'h100);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
`ifdef FLGHT_MIXER_SLEW_EN
    chk("first_update_bck", 32'(bus.bck_spd), 'h2A0);
`else
    chk("first_update_bck", 32'(bus.bck_spd), 'h3C0);
`endif
    for (int k = 0; k < 25; k++) cyc(1, 0, 1);

    // Random traffic: back-to-back samples, queue wrap, mode changes
    cal_lvl = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(99) < 3) cal_lvl = ~cal_lvl;
      a_rnd = ($urandom_range(99) >= 2);
      bus.d_ptch = rnd_ang();
      bus.d_roll = rnd_ang();
      bus.d_yaw  = rnd_ang();
      bus.ptch   = rnd_ang();
      bus.roll   = rnd_ang();
      bus.yaw    = rnd_ang();
      bus.thrst  = THRST_W'($urandom);
      cyc(a_rnd, cal_lvl, 1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
